freq_meas_ctrl: RTL
===================

FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 SHALL have parameter GATE_DEFAULT, default 100000000, reset value of GATE_LEN (csi_clk cycles).
REQ-002 SHALL have parameter TIMEOUT_DEFAULT, default 200000000, reset value of TIMEOUT (csi_clk cycles).
REQ-003 SHALL have ports:
- csi_clk  in  1  sole clock, also the reference clock.
- csi_reset  in  1  asynchronous, active-high reset.
- avs_chipselect  in  1  Avalon-MM select.
- avs_address  in  3  register index.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data.
- ins_irq  out  1  measurement-complete interrupt.
- coe_sig_in  in  1  asynchronous signal under test.
- coe_gate  out  1  high while state is GATE or CLOSE.
- coe_busy  out  1  high while state is not IDLE.

Function
REQ-004 Register map SHALL be:
- 0 CTRL, R/W: bit0 start (write-only, self-clearing pulse), bit1 continuous, bit2 abort (write-only pulse), bit3 irq_en.
- 1 STATUS: bit0 busy, bit1 done, bit2 timeout, bit3 overflow; writing 1 to bit1 clears done, timeout and overflow.
- 2 GATE_LEN, R/W.
- 3 TIMEOUT, R/W.
- 4 REF_RESULT, R.
- 5 TEST_RESULT, R.
- 6 SEQ_COUNT, R.
- 7 reads 0.
REQ-005 avs_readdata SHALL be combinational, zero wait states: the selected register when avs_chipselect & avs_read, else 0.
REQ-006 coe_sig_in SHALL pass through a 2-FF synchronizer plus one delay FF; edge pulse = sync2 & ~sync3, i.e. 3 cycles of latency from the input; the signal under test is limited to below fclk/2.
REQ-007 The FSM SHALL have states IDLE, CLEAR, ARM, GATE, CLOSE, DONE.
REQ-008 Transitions SHALL be:
- IDLE -> CLEAR on start.
- CLEAR (1 cycle): zero the counters and timer, latch GATE_LEN (0 treated as 1) and TIMEOUT -> ARM.
- ARM -> GATE on an edge pulse (this opening edge is not counted).
- GATE -> CLOSE when gate timer == latched GATE_LEN-1.
- CLOSE -> DONE on an edge pulse.
- DONE (1 cycle) -> CLEAR if continuous, else IDLE.
REQ-009 ref_cnt SHALL increment every cycle in GATE and CLOSE; test_cnt SHALL increment on each edge pulse in GATE and CLOSE, including the closing edge.
REQ-010 An edge pulse in the cycle GATE expires SHALL be counted; CLOSE then waits for the next edge.
REQ-011 Each counter SHALL saturate at 0xFFFFFFFF and set overflow.
REQ-012 A timeout counter SHALL run in ARM and CLOSE; reaching latched TIMEOUT SHALL go to DONE with timeout=1 and REF_RESULT=TEST_RESULT=0.
REQ-013 In DONE: REF_RESULT<=ref_cnt, TEST_RESULT<=test_cnt, done<=1, SEQ_COUNT increments (wrapping at 2^32).
REQ-014 ins_irq SHALL equal done & irq_en.
REQ-015 Start while not IDLE SHALL be ignored.
REQ-016 Abort SHALL return to IDLE on the next cycle from any state; results, done and SEQ_COUNT are unchanged.
REQ-017 Abort and start in the same write SHALL execute abort only.
REQ-018 GATE_LEN/TIMEOUT writes while busy SHALL take effect at the next CLEAR.
REQ-019 Clearing done in the same cycle DONE sets it SHALL leave done=1 (set wins).
REQ-020 Clearing continuous while busy SHALL let the current measurement finish, then go to IDLE.

Reset
REQ-021 While csi_reset=1 the block SHALL be forced to: state IDLE; CTRL=0; status flags 0; GATE_LEN=GATE_DEFAULT; TIMEOUT=TIMEOUT_DEFAULT; results, SEQ_COUNT, counters and synchronizer 0; ins_irq=coe_gate=coe_busy=0.
REQ-022 Reset asserted mid-measurement SHALL discard the measurement without updating results.

Verification
REQ-023 Bench SHALL cover these scenarios:
- GATE_LEN=1000, coe_sig_in period 10 clk, start -> REF_RESULT=1010, TEST_RESULT=101, done=1, SEQ_COUNT=1.
- coe_sig_in static, TIMEOUT=500, irq_en=1, start -> after 501 cycles in ARM: done=1, timeout=1, results 0, ins_irq=1; write STATUS bit1=1 -> ins_irq=0.
- Continuous=1, GATE_LEN=100, period 4 -> SEQ_COUNT increments every measurement, REF_RESULT=TEST_RESULT*4; clear continuous -> stops in IDLE after the current measurement.
- Abort written during GATE -> coe_busy=0 next cycle, prior results unchanged, done unchanged.
- csi_reset pulsed during CLOSE -> all registers at reset values, GATE_LEN=100000000.
- Start while busy and start+abort in one write -> no restart; IDLE.

Source files
------------

// File: rtl/freq_meas_ctrl.sv
// Reciprocal-style frequency meter with an Avalon-MM register interface.
// A gate of GATE_LEN reference cycles is opened on a rising edge of the signal under test.
// The gate is held open past expiry until the next edge, so both counters span whole periods.
//
// Ports:
//   csi_clk         sole clock, also the reference clock
//   csi_reset       asynchronous active-high reset
//   avs_*           Avalon-MM slave: 3-bit word address, 32-bit data, zero-wait-state reads
//   ins_irq         measurement-complete interrupt (done & irq_en)
//   coe_sig_in      asynchronous signal under test
//   coe_gate        high while the gate is open (GATE or CLOSE)
//   coe_busy        high while a measurement is in progress
module freq_meas_ctrl #(
    parameter int unsigned GATE_DEFAULT    = 100000000,
    parameter int unsigned TIMEOUT_DEFAULT = 200000000
) (
    input  logic        csi_clk,
    input  logic        csi_reset,
    input  logic        avs_chipselect,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        ins_irq,
    input  logic        coe_sig_in,
    output logic        coe_gate,
    output logic        coe_busy
);

    typedef enum logic [2:0] {StIdle, StClear, StArm, StGate, StClose, StDone} state_e;

    localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

    state_e      state_q, state_d;
    logic        cont_q, cont_d, irq_en_q, irq_en_d;
    logic        done_q, done_d, timeout_q, timeout_d, ovf_q, ovf_d;
    logic [31:0] gate_len_q, gate_len_d, timeout_len_q, timeout_len_d;
    logic [31:0] gate_lat_q, gate_lat_d, tmo_lat_q, tmo_lat_d;
    logic [31:0] ref_cnt_q, ref_cnt_d, test_cnt_q, test_cnt_d, timer_q, timer_d;
    logic [31:0] ref_res_q, ref_res_d, test_res_q, test_res_d, seq_q, seq_d;
    logic        tmo_hit_q, tmo_hit_d;
    logic [2:0]  sync_q;

    logic wr_en, ctrl_wr, start_req, abort_req, status_clr, sig_rise;

    assign wr_en      = avs_chipselect & avs_write;
    assign ctrl_wr    = wr_en && (avs_address == 3'd0);
    // Abort takes precedence over a start carried in the same write.
    assign start_req  = ctrl_wr & avs_writedata[0] & ~avs_writedata[2];
    assign abort_req  = ctrl_wr & avs_writedata[2];
    assign status_clr = wr_en && (avs_address == 3'd1) && avs_writedata[1];

    // sync_q[0..1] synchronize, sync_q[2] is the delayed copy for edge detection.
    assign sig_rise = sync_q[1] & ~sync_q[2];

    assign coe_busy = (state_q != StIdle);
    assign coe_gate = (state_q == StGate) || (state_q == StClose);
    assign ins_irq  = done_q & irq_en_q;

    always_comb begin
        state_d       = state_q;
        cont_d        = cont_q;
        irq_en_d      = irq_en_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        ovf_d         = ovf_q;
        gate_len_d    = gate_len_q;
        timeout_len_d = timeout_len_q;
        gate_lat_d    = gate_lat_q;
        tmo_lat_d     = tmo_lat_q;
        ref_cnt_d     = ref_cnt_q;
        test_cnt_d    = test_cnt_q;
        timer_d       = timer_q;
        ref_res_d     = ref_res_q;
        test_res_d    = test_res_q;
        seq_d         = seq_q;
        tmo_hit_d     = tmo_hit_q;

        if (ctrl_wr) begin
            cont_d   = avs_writedata[1];
            irq_en_d = avs_writedata[3];
        end
        if (wr_en && (avs_address == 3'd2)) gate_len_d = avs_writedata;
        if (wr_en && (avs_address == 3'd3)) timeout_len_d = avs_writedata;
        // Cleared here so that a set from the FSM below wins in the same cycle.
        if (status_clr) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
            ovf_d     = 1'b0;
        end

        // Counting while the gate is open, saturating with a sticky overflow flag.
        if ((state_q == StGate) || (state_q == StClose)) begin
            if (ref_cnt_q == CntMax) ovf_d = 1'b1;
            else ref_cnt_d = ref_cnt_q + 32'd1;
            if (sig_rise) begin
                if (test_cnt_q == CntMax) ovf_d = 1'b1;
                else test_cnt_d = test_cnt_q + 32'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start_req) state_d = StClear;
            end
            StClear: begin
                ref_cnt_d  = '0;
                test_cnt_d = '0;
                timer_d    = '0;
                tmo_hit_d  = 1'b0;
                gate_lat_d = (gate_len_q == '0) ? 32'd1 : gate_len_q;
                tmo_lat_d  = timeout_len_q;
                state_d    = StArm;
            end
            StArm: begin
                // The opening edge only starts the gate; it is not counted.
                if (sig_rise) begin
                    timer_d = '0;
                    state_d = StGate;
                end else if (timer_q == tmo_lat_q) begin
                    tmo_hit_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StGate: begin
                if (timer_q == gate_lat_q - 32'd1) begin
                    timer_d = '0;
                    state_d = StClose;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StClose: begin
                if (sig_rise) begin
                    state_d = StDone;
                end else if (timer_q == tmo_lat_q) begin
                    tmo_hit_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            StDone: begin
                if (!abort_req) begin
                    if (tmo_hit_q) begin
                        ref_res_d  = '0;
                        test_res_d = '0;
                        timeout_d  = 1'b1;
                    end else begin
                        ref_res_d  = ref_cnt_q;
                        test_res_d = test_cnt_q;
                    end
                    done_d = 1'b1;
                    seq_d  = seq_q + 32'd1;
                end
                state_d = cont_q ? StClear : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort_req) state_d = StIdle;
    end

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            state_q       <= StIdle;
            cont_q        <= 1'b0;
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            ovf_q         <= 1'b0;
            gate_len_q    <= GATE_DEFAULT;
            timeout_len_q <= TIMEOUT_DEFAULT;
            gate_lat_q    <= '0;
            tmo_lat_q     <= '0;
            ref_cnt_q     <= '0;
            test_cnt_q    <= '0;
            timer_q       <= '0;
            ref_res_q     <= '0;
            test_res_q    <= '0;
            seq_q         <= '0;
            tmo_hit_q     <= 1'b0;
            sync_q        <= '0;
        end else begin
            state_q       <= state_d;
            cont_q        <= cont_d;
            irq_en_q      <= irq_en_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            ovf_q         <= ovf_d;
            gate_len_q    <= gate_len_d;
            timeout_len_q <= timeout_len_d;
            gate_lat_q    <= gate_lat_d;
            tmo_lat_q     <= tmo_lat_d;
            ref_cnt_q     <= ref_cnt_d;
            test_cnt_q    <= test_cnt_d;
            timer_q       <= timer_d;
            ref_res_q     <= ref_res_d;
            test_res_q    <= test_res_d;
            seq_q         <= seq_d;
            tmo_hit_q     <= tmo_hit_d;
            sync_q        <= {sync_q[1:0], coe_sig_in};
        end
    end

    always_comb begin
        avs_readdata = '0;
        if (avs_chipselect && avs_read) begin
            case (avs_address)
                3'd0: avs_readdata = {28'd0, irq_en_q, 1'b0, cont_q, 1'b0};
                3'd1: avs_readdata = {28'd0, ovf_q, timeout_q, done_q, coe_busy};
                3'd2: avs_readdata = gate_len_q;
                3'd3: avs_readdata = timeout_len_q;
                3'd4: avs_readdata = ref_res_q;
                3'd5: avs_readdata = test_res_q;
                3'd6: avs_readdata = seq_q;
                default: avs_readdata = '0;
            endcase
        end
    end

endmodule
